// File: rtl/dram_word_adapter.sv
// rtl/dram_word_adapter.sv - 32-bit CPU word requests to 128-bit DRAM line commands.
// Keeps a single write-through line buffer so repeated reads of a line skip DRAM.
module dram_word_adapter #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16,
  parameter int USE_LINE_BUF   = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_x,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_we,
  input  logic [31:0]               i_req_addr,
  input  logic [31:0]               i_req_wdata,
  input  logic [3:0]                i_req_be,
  output logic                      o_resp_valid,
  output logic [31:0]               o_resp_rdata,
  output logic                      o_dram_rd_en,
  output logic                      o_dram_wr_en,
  output logic [APP_ADDR_WIDTH-1:0] o_dram_addr,
  output logic [APP_DATA_WIDTH-1:0] o_dram_data,
  output logic [APP_MASK_WIDTH-1:0] o_dram_mask,
  input  logic [APP_DATA_WIDTH-1:0] i_dram_data,
  input  logic                      i_dram_data_valid,
  input  logic                      i_dram_ready
);

  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_DRAIN, RD_ISSUE, RD_WAIT, RESP} state_t;

  state_t                    state_q, state_d;
  logic [29:0]               addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                be_q, be_d;
  logic                      ready_q, ready_d;
  logic                      drain_q, drain_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      buf_valid_q, buf_valid_d;
  logic [27:0]               buf_tag_q, buf_tag_d;
  logic [APP_DATA_WIDTH-1:0] buf_data_q, buf_data_d;

  logic                      accept;
  logic                      hit;
  logic [APP_DATA_WIDTH-1:0] merged;
  logic                      unused_addr;

  function automatic logic [31:0] lane_sel(input logic [APP_DATA_WIDTH-1:0] line,
                                           input logic [1:0] n);
    return line[{n, 5'b00000} +: 32];
  endfunction

  assign unused_addr = ^i_req_addr[1:0];
  assign accept      = i_req_valid & ready_q;
  assign hit         = (USE_LINE_BUF != 0) && buf_valid_q && (buf_tag_q == i_req_addr[31:4]);

  // Write-through merge of the incoming word into the buffered line.
  always_comb begin
    merged = buf_data_q;
    for (int b = 0; b < 4; b++) begin
      if (i_req_be[b]) begin
        merged[{i_req_addr[3:2], 5'b00000} + 7'(8 * b) +: 8] = i_req_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    drain_d      = drain_q;
    rdata_d      = rdata_q;
    buf_valid_d  = buf_valid_q;
    buf_tag_d    = buf_tag_q;
    buf_data_d   = buf_data_q;
    o_resp_valid = 1'b0;
    o_dram_rd_en = 1'b0;
    o_dram_wr_en = 1'b0;
    o_dram_addr  = '0;
    o_dram_data  = '0;
    o_dram_mask  = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = i_req_addr[31:2];
          wdata_d = i_req_wdata;
          be_d    = i_req_be;
          if (i_req_we) begin
            state_d = WR_ISSUE;
            if (hit) buf_data_d = merged;
          end else if (hit) begin
            rdata_d = lane_sel(buf_data_q, i_req_addr[3:2]);
            state_d = RESP;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      WR_ISSUE: begin
        o_dram_addr = {addr_q[APP_ADDR_WIDTH-2:2], 3'b000};
        o_dram_data = {(APP_DATA_WIDTH/32){wdata_q}};
        o_dram_mask = ~({{(APP_MASK_WIDTH-4){1'b0}}, be_q} << {addr_q[1:0], 2'b00});
        if (i_dram_ready) begin
          o_dram_wr_en = 1'b1;
          drain_d      = 1'b1;
          state_d      = WR_DRAIN;
        end
      end
      WR_DRAIN: begin
        // The controller still shows ready in the cycle right after the command.
        if (drain_q)           drain_d = 1'b0;
        else if (i_dram_ready) state_d = RESP;
      end
      RD_ISSUE: begin
        o_dram_addr = {addr_q[APP_ADDR_WIDTH-2:2], 3'b000};
        if (i_dram_ready) begin
          o_dram_rd_en = 1'b1;
          state_d      = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (i_dram_data_valid) begin
          rdata_d = lane_sel(i_dram_data, addr_q[1:0]);
          if (USE_LINE_BUF != 0) begin
            buf_data_d  = i_dram_data;
            buf_tag_d   = addr_q[29:2];
            buf_valid_d = 1'b1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        o_resp_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      ready_q     <= 1'b0;
      drain_q     <= 1'b0;
      rdata_q     <= '0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      ready_q     <= ready_d;
      drain_q     <= drain_d;
      rdata_q     <= rdata_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end

  assign o_req_ready  = ready_q;
  assign o_resp_rdata = rdata_q;

endmodule

// File: tb/tb_dram_word_adapter.sv
// tb/tb_dram_word_adapter.sv - scoreboard bench for dram_word_adapter.
// Instance 0 has the line buffer, instance 1 sends every read to DRAM.
module tb_dram_word_adapter;

  localparam logic [127:0] LINE = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};

  typedef struct packed {
    logic        dut;
    logic        wr;
    logic [31:0] d;
  } exp_t;

  logic clk;
  logic rst_n;

  logic         req_valid [2];
  logic         req_we    [2];
  logic [31:0]  req_addr  [2];
  logic [31:0]  req_wdata [2];
  logic [3:0]   req_be    [2];
  logic         req_ready [2];
  logic         resp_valid[2];
  logic [31:0]  rdata     [2];
  logic         rd_en     [2];
  logic         wr_en     [2];
  logic [27:0]  dram_addr [2];
  logic [127:0] dram_wdata[2];
  logic [15:0]  dram_mask [2];
  logic [127:0] dram_rdata[2];
  logic         dram_dv   [2];
  logic         dram_ready[2];
  logic         hold      [2];

  int total = 0;
  int bad   = 0;

  exp_t         sb[$];
  int           resp_cnt[2];
  int           rd_seen [2];
  int           wr_seen [2];
  int           dv_seen [2];
  logic [27:0]  rd_addr [2];
  logic [15:0]  rd_mask [2];
  logic [27:0]  wr_addr [2];
  logic [15:0]  wr_mask [2];
  logic [127:0] wr_data [2];

  int           rcnt [2];
  int           wcnt [2];
  logic [27:0]  raddr[2];
  logic [127:0] mem  [int];

  dram_word_adapter #(.USE_LINE_BUF(1)) u_dut0 (
    .i_clk(clk), .i_rst_x(rst_n),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_we(req_we[0]),
    .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]), .i_req_be(req_be[0]),
    .o_resp_valid(resp_valid[0]), .o_resp_rdata(rdata[0]),
    .o_dram_rd_en(rd_en[0]), .o_dram_wr_en(wr_en[0]), .o_dram_addr(dram_addr[0]),
    .o_dram_data(dram_wdata[0]), .o_dram_mask(dram_mask[0]),
    .i_dram_data(dram_rdata[0]), .i_dram_data_valid(dram_dv[0]), .i_dram_ready(dram_ready[0])
  );

  dram_word_adapter #(.USE_LINE_BUF(0)) u_dut1 (
    .i_clk(clk), .i_rst_x(rst_n),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_we(req_we[1]),
    .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]), .i_req_be(req_be[1]),
    .o_resp_valid(resp_valid[1]), .o_resp_rdata(rdata[1]),
    .o_dram_rd_en(rd_en[1]), .o_dram_wr_en(wr_en[1]), .o_dram_addr(dram_addr[1]),
    .o_dram_data(dram_wdata[1]), .o_dram_mask(dram_mask[1]),
    .i_dram_data(dram_rdata[1]), .i_dram_data_valid(dram_dv[1]), .i_dram_ready(dram_ready[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Controller model: 5-cycle read latency, 3-cycle write busy, byte-masked line memory.
  initial begin
    for (int k = 0; k < 2; k++) begin
      dram_ready[k] = 1'b0; dram_dv[k] = 1'b0; dram_rdata[k] = '0;
      rcnt[k] = 0; wcnt[k] = 0; raddr[k] = '0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        int key;
        logic [127:0] line;
        dram_dv[k] <= 1'b0;
        if (rd_en[k]) begin
          rcnt[k]  <= 5;
          raddr[k] <= dram_addr[k];
        end else if (rcnt[k] > 0) begin
          rcnt[k] <= rcnt[k] - 1;
          if (rcnt[k] == 1) begin
            key = k * 32'h1000_0000 + int'(raddr[k]);
            dram_dv[k]    <= 1'b1;
            dram_rdata[k] <= mem.exists(key) ? mem[key] : LINE;
          end
        end
        if (wr_en[k]) begin
          key  = k * 32'h1000_0000 + int'(dram_addr[k]);
          line = mem.exists(key) ? mem[key] : LINE;
          for (int b = 0; b < 16; b++)
            if (!dram_mask[k][b]) line[8*b +: 8] = dram_wdata[k][8*b +: 8];
          mem[key] = line;
          wcnt[k] <= 3;
        end else if (wcnt[k] > 0) begin
          wcnt[k] <= wcnt[k] - 1;
        end
        dram_ready[k] <= !hold[k] && !rd_en[k] && !wr_en[k] && rcnt[k] <= 1 && wcnt[k] <= 1;
      end
    end
  end

  // Monitor: pops the scoreboard on each response and records command pulses.
  initial begin
    logic prev_resp[2];
    logic prev_cmd [2];
    logic prev_rdy [2];
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      prev_resp[k] = 1'b0; prev_cmd[k] = 1'b0; prev_rdy[k] = 1'b0;
      resp_cnt[k] = 0; rd_seen[k] = 0; wr_seen[k] = 0; dv_seen[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (resp_valid[k]) begin
          resp_cnt[k]++;
          if (prev_resp[k]) check("resp_one_cycle", 1, 0);
          if (sb.size() == 0) begin
            check("unexpected_resp", 1, 0);
          end else begin
            e = sb.pop_front();
            check("resp_dut", 128'(k), 128'(e.dut));
            check("resp_rdata", rdata[k], e.d);
            if (e.wr) check("wr_resp_after_ready", prev_rdy[k], 1);
          end
        end
        if (dram_dv[k]) dv_seen[k]++;
        if (rd_en[k]) begin
          rd_seen[k]++; rd_addr[k] = dram_addr[k]; rd_mask[k] = dram_mask[k];
        end
        if (wr_en[k]) begin
          wr_seen[k]++; wr_addr[k] = dram_addr[k]; wr_mask[k] = dram_mask[k];
          wr_data[k] = dram_wdata[k];
        end
        if (rd_en[k] && wr_en[k]) check("rd_wr_together", 1, 0);
        if ((rd_en[k] || wr_en[k]) && prev_cmd[k]) check("cmd_back_to_back", 1, 0);
        prev_resp[k] = resp_valid[k];
        prev_cmd[k]  = rd_en[k] || wr_en[k];
        prev_rdy[k]  = dram_ready[k];
      end
    end
  end

  task automatic do_req(input int k, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    int n = 0;
    @(negedge clk);
    while (!req_ready[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[k]) check("req_ready_timeout", 0, 1);
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a; req_wdata[k] = wd; req_be[k] = be;
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
  endtask

  task automatic wait_resp(input int k, input int start);
    int n = 0;
    while (resp_cnt[k] <= start && n < 200) begin
      @(negedge clk);
      #1 n++;
    end
    if (resp_cnt[k] <= start) check("resp_timeout", 0, 1);
  endtask

  task automatic push(input int k, input logic wr, input logic [31:0] d);
    exp_t e;
    e.dut = k[0]; e.wr = wr; e.d = d;
    sb.push_back(e);
  endtask

  initial begin
    int start, rd0, dv0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; req_be[k] = '0; hold[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready[0], 0);
    check("rst_resp_valid", resp_valid[0], 0);
    check("rst_rdata", rdata[0], 0);
    check("rst_rd_en", rd_en[0], 0);
    check("rst_wr_en", wr_en[0], 0);
    check("rst_dram_addr", dram_addr[0], 0);
    check("rst_dram_mask", dram_mask[0], 0);
    check("rst_dram_data", dram_wdata[0], 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", req_ready[0], 1);

    // Miss read fills the buffer.
    start = resp_cnt[0];
    push(0, 0, 32'hAAAA_AAAA);
    do_req(0, 0, 32'h0000_0010, 0, 0);
    wait_resp(0, start);
    check("rd_count_miss", rd_seen[0], 1);
    check("rd_addr", rd_addr[0], 28'h000_0008);
    check("rd_mask", rd_mask[0], 0);

    // Hit read: one cycle latency, no DRAM access.
    start = resp_cnt[0];
    push(0, 0, 32'hDDDD_DDDD);
    do_req(0, 0, 32'h0000_001C, 0, 0);
    @(negedge clk);
    check("hit_latency", resp_valid[0], 1);
    wait_resp(0, start);
    check("rd_count_hit", rd_seen[0], 1);

    // Partial write merges into buffer and goes through to DRAM.
    start = resp_cnt[0];
    push(0, 1, 32'hDDDD_DDDD);
    do_req(0, 1, 32'h0000_0018, 32'h1234_5678, 4'b0011);
    wait_resp(0, start);
    check("wr_count", wr_seen[0], 1);
    check("wr_addr", wr_addr[0], 28'h000_0008);
    check("wr_mask", wr_mask[0], 16'hFCFF);
    check("wr_data", wr_data[0], {4{32'h1234_5678}});

    start = resp_cnt[0];
    push(0, 0, 32'hCCCC_5678);
    do_req(0, 0, 32'h0000_0018, 0, 0);
    wait_resp(0, start);
    check("rd_count_merged_hit", rd_seen[0], 1);

    // Controller busy for 10 cycles with a pending write.
    hold[0] = 1'b1;
    repeat (2) @(negedge clk);
    start = resp_cnt[0];
    push(0, 1, 32'hCCCC_5678);
    do_req(0, 1, 32'h0000_0024, 32'hA5A5_A5A5, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_wr_en", wr_en[0], 0);
      check("hold_req_ready", req_ready[0], 0);
    end
    hold[0] = 1'b0;
    wait_resp(0, start);
    check("hold_wr_count", wr_seen[0], 2);
    check("hold_wr_addr", wr_addr[0], 28'h000_0010);
    check("hold_wr_mask", wr_mask[0], 16'hFF0F);

    // Reset during RD_WAIT; the late line must be ignored.
    start = resp_cnt[0];
    rd0   = rd_seen[0];
    do_req(0, 0, 32'h0000_0040, 0, 0);
    for (int i = 0; i < 20 && rd_seen[0] == rd0; i++) @(negedge clk);
    check("abort_rd_issued", rd_seen[0], rd0 + 1);
    dv0 = dv_seen[0];
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_rst_resp_valid", resp_valid[0], 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("stale_dv_delivered", dv_seen[0], dv0 + 1);
    check("stale_no_resp", resp_cnt[0], start);
    check("stale_rdata_reset", rdata[0], 0);

    start = resp_cnt[0];
    push(0, 0, 32'hCCCC_5678);
    do_req(0, 0, 32'h0000_0018, 0, 0);
    wait_resp(0, start);
    check("post_reset_miss", rd_seen[0], rd0 + 2);

    // No line buffer: every read goes to DRAM.
    start = resp_cnt[1];
    push(1, 0, 32'hAAAA_AAAA);
    do_req(1, 0, 32'h0000_0010, 0, 0);
    wait_resp(1, start);
    start = resp_cnt[1];
    push(1, 0, 32'hBBBB_BBBB);
    do_req(1, 0, 32'h0000_0014, 0, 0);
    wait_resp(1, start);
    check("nobuf_rd_count", rd_seen[1], 2);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_word_adapter.md
Name: dram_word_adapter

Overview:
- Sits directly upstream of the DRAM AXI controller and converts single-outstanding 32-bit CPU word requests into 128-bit line commands on the controller's user port (rd_en/wr_en/addr/data/mask).
- Returns the read word to the CPU.
- Holds a one-line read buffer so repeated reads to the same 16-byte line complete without a DRAM access.

Parameters:
- APP_ADDR_WIDTH, 28, controller address width (16-bit-unit addressing).
- APP_DATA_WIDTH, 128, controller line width.
- APP_MASK_WIDTH, 16, controller byte-mask width (1 = byte not written).
- USE_LINE_BUF, 1, 1 enables the read line buffer; 0 sends every read to DRAM.

Ports:
- i_clk  in  1  clock.
- i_rst_x  in  1  asynchronous active-low reset.
- i_req_valid  in  1  CPU request valid.
- o_req_ready  out  1  adapter can accept a request.
- i_req_we  in  1  1 = write, 0 = read.
- i_req_addr  in  32  CPU byte address; bits [1:0] ignored.
- i_req_wdata  in  32  write word.
- i_req_be  in  4  write byte enables.
- o_resp_valid  out  1  one-cycle completion pulse (reads and writes).
- o_resp_rdata  out  32  read word, valid with o_resp_valid on reads.
- o_dram_rd_en  out  1  read command pulse to controller.
- o_dram_wr_en  out  1  write command pulse to controller.
- o_dram_addr  out  APP_ADDR_WIDTH  line address = {i_req_addr[APP_ADDR_WIDTH:4], 3'b000}.
- o_dram_data  out  APP_DATA_WIDTH  write data; the word is replicated into all four 32-bit lanes.
- o_dram_mask  out  APP_MASK_WIDTH  byte mask = ~({12'b0, i_req_be} << 4*i_req_addr[3:2]).
- i_dram_data  in  APP_DATA_WIDTH  read line from controller.
- i_dram_data_valid  in  1  read line valid.
- i_dram_ready  in  1  controller idle and able to accept a command.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE.
  - All outputs 0.
  - Line buffer valid=0, tag=0, data=0.
- States: IDLE, WR_ISSUE, WR_DRAIN, RD_ISSUE, RD_WAIT, RESP.
- o_req_ready=1 only in IDLE. A request is accepted on i_req_valid & o_req_ready; addr, we, wdata and be are registered at acceptance.
- IDLE, read, buffer hit (USE_LINE_BUF=1, valid=1, tag==addr[31:4]):
  - Go to RESP.
  - o_resp_rdata = buffered word addr[3:2].
  - Latency from acceptance to o_resp_valid: 1 cycle.
- IDLE, read, miss: go to RD_ISSUE.
- IDLE, write: go to WR_ISSUE.
- WR_ISSUE:
  - Wait for i_dram_ready=1.
  - In that cycle assert o_dram_wr_en for exactly 1 cycle, with o_dram_addr, o_dram_data and o_dram_mask valid in the same cycle.
  - Go to WR_DRAIN.
- WR_DRAIN:
  - Ignore i_dram_ready in the first cycle, since the controller deasserts it one cycle after the command.
  - Afterwards wait for i_dram_ready=1, then go to RESP.
- RD_ISSUE:
  - Same rule as WR_ISSUE but pulse o_dram_rd_en.
  - o_dram_mask=0, o_dram_data don't-care.
  - Go to RD_WAIT.
- RD_WAIT:
  - On i_dram_data_valid, capture the line.
  - If USE_LINE_BUF: load buffer data, tag=addr[31:4], valid=1.
  - Select word addr[3:2] into o_resp_rdata and go to RESP.
  - Controller read latency is unbounded; no timeout.
- RESP:
  - o_resp_valid=1 for exactly one cycle, then go to IDLE.
  - o_resp_rdata is held until the next read response; writes leave it unchanged.
- Never assert rd_en and wr_en together. Never pulse either in consecutive cycles.
- Write vs line buffer: on write acceptance with valid=1 and a tag match, merge the enabled bytes into the buffer in the same cycle (write-through). The buffer never holds stale data.
- i_dram_data_valid outside RD_WAIT is ignored.
- i_req_valid while o_req_ready=0 is not accepted; the CPU must hold the request.
- Word select: lane n = i_dram_data[32n+31:32n], where n = addr[3:2].
- Reset asserted mid-operation aborts immediately: state IDLE, outputs 0, buffer invalid. A pending controller response after reset is ignored because the state is not RD_WAIT.

Test Plan:
- Reset, then read 0x0000_0010 with i_dram_ready=1; model returns line {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA} 5 cycles later:
  - one o_dram_rd_en pulse with o_dram_addr=0x0000008.
  - o_resp_rdata=0xAAAA_AAAA, one-cycle o_resp_valid.
- Then read 0x0000_001C:
  - no rd_en.
  - o_resp_valid 1 cycle after acceptance with 0xDDDD_DDDD.
- Write 0x0000_0018, wdata 0x1234_5678, be=4'b0011:
  - o_dram_mask=16'hFCFF.
  - o_dram_data=4×0x1234_5678.
  - o_resp_valid only after i_dram_ready returns.
  - Subsequent read 0x18 hits and returns 0xCCCC_5678.
- Hold i_dram_ready=0 for 10 cycles with a pending write:
  - o_dram_wr_en stays 0 and o_req_ready stays 0.
  - Single pulse on the first ready cycle.
- Assert i_rst_x=0 during RD_WAIT, release, then deliver stale i_dram_data_valid:
  - no o_resp_valid.
  - next read to the same line misses and issues rd_en.
- USE_LINE_BUF=0, two reads to the same line: two rd_en pulses.
